hcordic_iter_engine: RTL

//  Iterative hyperbolic CORDIC engine that generalises the fixed combinational stage.
//  - Runs every micro-rotation i=1..N_ITER on one shared datapath, one step per cycle.
//  - Inserts the mandatory repeat steps at i=4,13,40.
//  - Runs in rotation mode (cosh/sinh) or vectoring mode (atanh/magnitude).
//  - Uses a valid/ready handshake on input and output.
//  - Sits between the argument pre-scaler and the result formatter.

---
 rtl/hcordic_pkg.sv | 50 +++++
 rtl/hcordic_iter_engine_step_unit.sv | 34 +++
 rtl/hcordic_iter_engine.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/hcordic_pkg.sv
// Shared constants, types and helpers for the iterative hyperbolic CORDIC engine.
// Angle and limit constants are kept at 32 fraction bits and truncated by the user.
package hcordic_pkg;

  localparam int unsigned DEF_INT_WIDTH = 3;
  localparam int unsigned DEF_FRA_WIDTH = 12;
  localparam int unsigned DEF_N_ITER    = 14;
  localparam int unsigned IDX_W         = 6;
  localparam int unsigned ATANH_FW      = 32;

  // 1.118, the hyperbolic rotation convergence bound
  localparam logic [63:0] CONV_LIMIT = 64'd4801773436;

  localparam logic [31:0] ATANH_TABLE [1:40] = '{
    32'h8C9F53D5, 32'h4162BBEA, 32'h202B1239, 32'h1005588A,
    32'h0800AAC4, 32'h04001556, 32'h020002AA, 32'h01000055,
    32'h0080000A, 32'h00400001, 32'h00200000, 32'h00100000,
    32'h00080000, 32'h00040000, 32'h00020000, 32'h00010000,
    32'h00008000, 32'h00004000, 32'h00002000, 32'h00001000,
    32'h00000800, 32'h00000400, 32'h00000200, 32'h00000100,
    32'h00000080, 32'h00000040, 32'h00000020, 32'h00000010,
    32'h00000008, 32'h00000004, 32'h00000002, 32'h00000001,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000
  };

  typedef enum logic {ROTATE = 1'b0, VECTOR = 1'b1} cordic_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } fsm_state_e;

  function automatic logic is_repeat_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(4)) || (i == IDX_W'(13)) || (i == IDX_W'(40));
  endfunction

  function automatic int unsigned steps_for(input int unsigned n);
    return n + ((n >= 32'd4)  ? 32'd1 : 32'd0)
             + ((n >= 32'd13) ? 32'd1 : 32'd0)
             + ((n >= 32'd40) ? 32'd1 : 32'd0);
  endfunction

  function automatic logic [31:0] atanh_raw(input logic [IDX_W-1:0] i);
    if ((i >= IDX_W'(1)) && (i <= IDX_W'(40))) return ATANH_TABLE[i];
    return 32'd0;
  endfunction

endpackage

// File: rtl/hcordic_iter_engine_step_unit.sv
// One combinational hyperbolic micro-rotation; shifts truncate toward -inf.
module hcordic_step_unit
  import hcordic_pkg::*;
#(
  parameter  int unsigned INT_WIDTH = DEF_INT_WIDTH,
  parameter  int unsigned FRA_WIDTH = DEF_FRA_WIDTH,
  localparam int unsigned DWIDTH    = 1 + INT_WIDTH + FRA_WIDTH
) (
  input  logic [DWIDTH-1:0] x_i,
  input  logic [DWIDTH-1:0] y_i,
  input  logic [DWIDTH-1:0] z_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  cordic_mode_e      mode_i,
  output logic [DWIDTH-1:0] x_o,
  output logic [DWIDTH-1:0] y_o,
  output logic [DWIDTH-1:0] z_o
);

  logic signed [DWIDTH-1:0] xsh, ysh;
  logic [DWIDTH-1:0]        ang;
  logic                     d_pos;

  assign xsh = $signed(x_i) >>> idx_i;
  assign ysh = $signed(y_i) >>> idx_i;
  assign ang = DWIDTH'(atanh_raw(idx_i) >> (ATANH_FW - FRA_WIDTH));

  // Rotation drives z toward 0, vectoring drives y toward 0
  assign d_pos = (mode_i == ROTATE) ? ~z_i[DWIDTH-1] : y_i[DWIDTH-1];

  assign x_o = d_pos ? (x_i + $unsigned(ysh)) : (x_i - $unsigned(ysh));
  assign y_o = d_pos ? (y_i + $unsigned(xsh)) : (y_i - $unsigned(xsh));
  assign z_o = d_pos ? (z_i - ang) : (z_i + ang);

endmodule

// File: rtl/hcordic_iter_engine.sv
// Iterative hyperbolic CORDIC: one micro-rotation per clock with repeat steps,
// valid/ready on both sides and a rotation-mode range flag.
module hcordic_iter_engine
  import hcordic_pkg::*;
#(
  parameter  int unsigned INT_WIDTH = DEF_INT_WIDTH,
  parameter  int unsigned FRA_WIDTH = DEF_FRA_WIDTH,
  parameter  int unsigned N_ITER    = DEF_N_ITER,
  localparam int unsigned DWIDTH    = 1 + INT_WIDTH + FRA_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [DWIDTH-1:0] x_in,
  input  logic [DWIDTH-1:0] y_in,
  input  logic [DWIDTH-1:0] z_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] x_out,
  output logic [DWIDTH-1:0] y_out,
  output logic [DWIDTH-1:0] z_out,
  output logic              out_range_err
);

  localparam int unsigned   AW        = DWIDTH + 1;
  localparam logic [AW-1:0] RANGE_LIM = AW'(CONV_LIMIT >> (ATANH_FW - FRA_WIDTH));

  fsm_state_e        state_q, state_d;
  cordic_mode_e      mode_q, mode_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              rep_q, rep_d;
  logic [DWIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [DWIDTH-1:0] xo_q, xo_d, yo_q, yo_d, zo_q, zo_d;
  logic              err_q, err_d;

  logic [DWIDTH-1:0] x_nx, y_nx, z_nx;
  logic [AW-1:0]     z_ext, z_abs;
  logic              accept;

  hcordic_step_unit #(
    .INT_WIDTH (INT_WIDTH),
    .FRA_WIDTH (FRA_WIDTH)
  ) u_step (
    .x_i    (x_q),
    .y_i    (y_q),
    .z_i    (z_q),
    .idx_i  (idx_q),
    .mode_i (mode_q),
    .x_o    (x_nx),
    .y_o    (y_nx),
    .z_o    (z_nx)
  );

  // Magnitude in one extra bit so the most negative operand does not wrap
  assign z_ext = {z_in[DWIDTH-1], z_in};
  assign z_abs = z_in[DWIDTH-1] ? (AW'(0) - z_ext) : z_ext;

  assign in_ready      = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept        = in_valid & in_ready;
  assign out_valid     = (state_q == DONE);
  assign x_out         = xo_q;
  assign y_out         = yo_q;
  assign z_out         = zo_q;
  assign out_range_err = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= ROTATE;
      idx_q   <= '0;
      rep_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      zo_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      zo_q    <= zo_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    zo_d    = zo_q;
    err_d   = err_q;

    case (state_q)
      IDLE: ;
      ITER: begin
        x_d = x_nx;
        y_d = y_nx;
        z_d = z_nx;
        if (is_repeat_idx(idx_q) && !rep_q) begin
          rep_d = 1'b1;
        end else begin
          rep_d = 1'b0;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(N_ITER)) begin
            state_d = DONE;
            xo_d    = x_nx;
            yo_d    = y_nx;
            zo_d    = z_nx;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Acceptance overrides a simultaneous pop so DONE can go straight to ITER
    if (accept) begin
      state_d = ITER;
      mode_d  = cordic_mode_e'(in_mode);
      idx_d   = IDX_W'(1);
      rep_d   = 1'b0;
      x_d     = x_in;
      y_d     = y_in;
      z_d     = z_in;
      err_d   = (cordic_mode_e'(in_mode) == ROTATE) && (z_abs > RANGE_LIM);
    end
  end

endmodule
